fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL have the following instruction-memory ports:
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  fetch address, word-aligned.
- imem_resp_valid  input  1  response data valid.
- imem_resp_data  input  32  fetched instruction.
REQ-004 The block SHALL have the following pipeline-control inputs:
- stall  input  1  hazard unit holds the IF/ID contents.
- redirect_valid  input  1  taken branch or jump; flush and refetch.
- redirect_pc  input  32  redirect target.
- halt  input  1  ecall halt; stop fetching permanently.
REQ-005 The block SHALL have the following IF/ID outputs:
- if_id_valid  output  1  IF/ID holds a live instruction.
- if_id_pc  output  32  PC of that instruction.
- if_id_inst  output  32  the instruction word.
- halted  output  1  the block is in the HALTED state.

Function
REQ-006 The block SHALL implement four states: FETCH (request asserted), WAIT (one request outstanding), HOLD (response buffered, IF/ID stalled) and HALTED.
REQ-007 In FETCH, imem_req_valid SHALL be 1 and imem_req_addr SHALL equal pc.
- Addr and valid SHALL stay stable until imem_req_ready=1.
- On acceptance the state SHALL go to WAIT and pc SHALL become pc+4, wrapping mod 2^32.
REQ-008 At most one request SHALL be outstanding, and imem_req_valid SHALL be 0 in WAIT, HOLD and HALTED.
REQ-009 The block SHALL tolerate any response latency of 1 or more cycles after acceptance.
REQ-010 A response arriving in WAIT when (!if_id_valid || !stall) SHALL be loaded into IF/ID on that edge.
- if_id_valid SHALL become 1 and if_id_pc SHALL be the accepted address.
- The state SHALL go to FETCH, so the next request is asserted the following cycle.
REQ-011 A response arriving in WAIT while if_id_valid=1 and stall=1 SHALL be captured into a one-entry hold buffer and the state SHALL go to HOLD.
REQ-012 In HOLD, the first cycle with stall=0 SHALL move the hold buffer into IF/ID and return the state to FETCH.
REQ-013 While stall=1, if_id_valid, if_id_pc and if_id_inst SHALL hold their values.
REQ-014 When IF/ID is drained (stall=0) and no response arrives that cycle, if_id_valid SHALL become 0.
REQ-015 redirect_valid=1 in cycle N SHALL have the following effect at edge N+1:
- It overrides stall.
- if_id_valid becomes 0, the hold buffer is cleared, and pc becomes {redirect_pc[31:2],2'b00}.
REQ-016 A redirect in FETCH with the request not yet accepted SHALL leave the state in FETCH with the new address from cycle N+1.
- A request accepted in cycle N itself SHALL be treated as outstanding and its response dropped.
REQ-017 A redirect in WAIT SHALL set a drop flag.
- The next response SHALL be discarded, leaving IF/ID invalid.
- The state SHALL then go to FETCH.
- A second redirect before that response SHALL only update pc.
REQ-018 A response arriving in the same cycle as redirect_valid SHALL be discarded.
REQ-019 halt=1 SHALL take the block to HALTED at the next edge, with priority over redirect and stall.
- if_id_valid SHALL become 0 and the hold buffer SHALL be cleared.
- halted SHALL become 1.
- Any outstanding response SHALL be ignored.
REQ-020 HALTED SHALL be left only by reset.
REQ-021 Simultaneous stall and response with IF/ID empty SHALL load IF/ID, because stall only holds a valid entry.

Reset
REQ-022 While reset=0, the block SHALL force pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_pc=0, if_id_inst=0, halted=0, drop flag=0 and hold buffer empty, asynchronously.
REQ-023 The first rising edge after reset deasserts SHALL see imem_req_valid=1 and imem_req_addr=RESET_PC.
REQ-024 Reset mid-transaction SHALL abandon the outstanding request, and no response before the first new request SHALL be consumed.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset with ready=1 and 1-cycle latency, memory returning addr+0x100 -> requests at 0x0, 0x4, 0x8; IF/ID shows (0x0, 0x100), then (0x4, 0x104), one instruction every 2 cycles.
- Response for 0x8 arrives with stall=1 and IF/ID valid at 0x4 -> state HOLD, IF/ID unchanged; stall drops -> IF/ID=(0x8, 0x108) next edge, then a new request at 0xC.
- Redirect to 0x43 in WAIT for 0x10 -> the 0x10 response is dropped, if_id_valid=0, next request at 0x40, IF/ID=(0x40, 0x140).
- halt=1 and redirect_valid=1 in the same cycle -> halted=1, if_id_valid=0, no further imem_req_valid until reset.
- imem_req_ready held at 0 for 5 cycles at addr 0x20 -> addr and valid stable throughout; accepted on cycle 6; pc advances once.
- redirect_pc=0xFFFFFFFC -> fetch at 0xFFFFFFFC, then the next request at 0x00000000 (wrap).

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding the IF/ID register,
// with a one-entry hold buffer for responses that land while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        halted
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALTED} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inflight_pc;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    logic        drop;
    logic        accept;
    logic        can_load;
    logic        unused_ok;

    assign imem_req_valid = (state == FETCH);
    assign imem_req_addr  = pc;
    assign halted         = (state == HALTED);
    assign accept         = imem_req_valid && imem_req_ready;
    assign can_load       = !if_id_valid || !stall;
    assign unused_ok      = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            hold_pc     <= '0;
            hold_inst   <= '0;
            drop        <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_inst  <= '0;
        end else if (state == HALTED) begin
            state <= HALTED;
        end else if (halt) begin
            state       <= HALTED;
            if_id_valid <= 1'b0;
            hold_pc     <= '0;
            hold_inst   <= '0;
            drop        <= 1'b0;
        end else if (redirect_valid) begin
            if_id_valid <= 1'b0;
            pc          <= {redirect_pc[31:2], 2'b00};
            case (state)
                // a request accepted in the redirect cycle is already in flight: drop its response
                FETCH: if (accept) begin
                    state <= WAIT;
                    drop  <= 1'b1;
                end
                WAIT: if (imem_resp_valid) begin
                    state <= FETCH;
                    drop  <= 1'b0;
                end else begin
                    drop <= 1'b1;
                end
                default: begin
                    state     <= FETCH;
                    hold_pc   <= '0;
                    hold_inst <= '0;
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) if_id_valid <= 1'b0;
                    if (accept) begin
                        state       <= WAIT;
                        inflight_pc <= pc;
                        pc          <= pc + 32'd4;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid && drop) begin
                        state <= FETCH;
                        drop  <= 1'b0;
                        if (!stall) if_id_valid <= 1'b0;
                    end else if (imem_resp_valid && can_load) begin
                        state       <= FETCH;
                        if_id_valid <= 1'b1;
                        if_id_pc    <= inflight_pc;
                        if_id_inst  <= imem_resp_data;
                    end else if (imem_resp_valid) begin
                        state     <= HOLD;
                        hold_pc   <= inflight_pc;
                        hold_inst <= imem_resp_data;
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end
                HOLD: if (!stall) begin
                    state       <= FETCH;
                    if_id_valid <= 1'b1;
                    if_id_pc    <= hold_pc;
                    if_id_inst  <= hold_inst;
                end
                default: state <= HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences, and a randomized run
// checked against an in-order instruction-stream model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall, redirect_valid, halt;
    logic [31:0] redirect_pc;
    logic        if_id_valid, halted;
    logic [31:0] if_id_pc, if_id_inst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
        .halted(halted)
    );

    typedef struct {
        logic        rdy, rv;
        logic [31:0] rd;
        logic        st, rdr;
        logic [31:0] rpc;
        logic        hlt;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        chk_addr;
        logic        e_iv;
        logic [31:0] e_ipc, e_iinst;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic st, input logic rdr, input logic [31:0] rpc,
                               input logic hlt, input logic e_rv, input logic [31:0] e_addr,
                               input logic chk_addr, input logic e_iv, input logic [31:0] e_ipc,
                               input logic [31:0] e_iinst, input logic e_halted);
        vec_t t;
        t.rdy = rdy; t.rv = rv; t.rd = rd; t.st = st; t.rdr = rdr; t.rpc = rpc; t.hlt = hlt;
        t.e_rv = e_rv; t.e_addr = e_addr; t.chk_addr = chk_addr; t.e_iv = e_iv;
        t.e_ipc = e_ipc; t.e_iinst = e_iinst; t.e_halted = e_halted;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd, input logic st,
                         input logic rdr, input logic [31:0] rpc, input logic hlt);
        imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rd;
        stall = st; redirect_valid = rdr; redirect_pc = rpc; halt = hlt;
    endtask

    // drive at negedge, let one rising edge happen, check at the following negedge
    task automatic run_vec(input vec_t t, input string tag);
        drive(t.rdy, t.rv, t.rd, t.st, t.rdr, t.rpc, t.hlt);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".req_valid"}, imem_req_valid, t.e_rv);
        if (t.chk_addr) check({tag, ".req_addr"}, imem_req_addr, t.e_addr);
        check({tag, ".if_id_valid"}, if_id_valid, t.e_iv);
        if (t.e_iv) begin
            check({tag, ".if_id_pc"}, if_id_pc, t.e_ipc);
            check({tag, ".if_id_inst"}, if_id_inst, t.e_iinst);
        end
        check({tag, ".halted"}, halted, t.e_halted);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, '0, 0, 0, '0, 0);
        reset = 1'b0;
        #1;
        check("rst.req_valid", imem_req_valid, 1);
        check("rst.req_addr", imem_req_addr, 32'h0);
        check("rst.if_id_valid", if_id_valid, 0);
        check("rst.if_id_pc", if_id_pc, 32'h0);
        check("rst.if_id_inst", if_id_inst, 32'h0);
        check("rst.halted", halted, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bit          pending;
        int unsigned cnt;
        logic [31:0] pend_data, exp_pc, prev_addr, prev_ipc, prev_iinst, rpc_r, acc_addr;
        logic        rdy_r, st_r, rdr_r, rv_r, accept_now;
        logic        prev_wait, prev_hold, prev_rdr;
        int          consumed;

        reset = 1'b0;
        drive(0, 0, '0, 0, 0, '0, 0);

        // basic flow, hold buffer, redirect in WAIT, stall on empty IF/ID, ready backpressure, wrap, halt
        vecs.push_back(v(1,0,32'h0,  0,0,32'h0,0, 0,32'h4,1, 0,32'h0,32'h0,   0));
        vecs.push_back(v(1,1,32'h100,0,0,32'h0,0, 1,32'h4,1, 1,32'h0,32'h100, 0));
        vecs.push_back(v(1,0,32'h0,  0,0,32'h0,0, 0,32'h8,1, 0,32'h0,32'h0,   0));
        vecs.push_back(v(1,1,32'h104,0,0,32'h0,0, 1,32'h8,1, 1,32'h4,32'h104, 0));
        vecs.push_back(v(1,0,32'h0,  1,0,32'h0,0, 0,32'hC,1, 1,32'h4,32'h104, 0));
        vecs.push_back(v(1,1,32'h108,1,0,32'h0,0, 0,32'hC,1, 1,32'h4,32'h104, 0));
        vecs.push_back(v(0,0,32'h0,  1,0,32'h0,0, 0,32'hC,1, 1,32'h4,32'h104, 0));
        vecs.push_back(v(0,0,32'h0,  0,0,32'h0,0, 1,32'hC,1, 1,32'h8,32'h108, 0));
        vecs.push_back(v(1,0,32'h0,  0,0,32'h0,0, 0,32'h10,1,0,32'h0,32'h0,   0));
        vecs.push_back(v(1,1,32'h10C,0,0,32'h0,0, 1,32'h10,1,1,32'hC,32'h10C, 0));
        vecs.push_back(v(1,0,32'h0,  0,0,32'h0,0, 0,32'h14,1,0,32'h0,32'h0,   0));
        vecs.push_back(v(0,0,32'h0,  0,1,32'h43,0,0,32'h40,1,0,32'h0,32'h0,   0));
        vecs.push_back(v(0,1,32'h110,0,0,32'h0,0, 1,32'h40,1,0,32'h0,32'h0,   0));
        vecs.push_back(v(1,0,32'h0,  0,0,32'h0,0, 0,32'h44,1,0,32'h0,32'h0,   0));
        vecs.push_back(v(0,1,32'h140,1,0,32'h0,0, 1,32'h44,1,1,32'h40,32'h140,0));
        vecs.push_back(v(0,0,32'h0,  0,0,32'h0,0, 1,32'h44,1,0,32'h0,32'h0,   0));
        vecs.push_back(v(0,0,32'h0,  0,1,32'h20,0,1,32'h20,1,0,32'h0,32'h0,   0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(0,0,32'h0,0,0,32'h0,0, 1,32'h20,1,0,32'h0,32'h0, 0));
        vecs.push_back(v(1,0,32'h0,  0,0,32'h0,0, 0,32'h24,1,0,32'h0,32'h0,   0));
        vecs.push_back(v(0,1,32'h120,0,0,32'h0,0, 1,32'h24,1,1,32'h20,32'h120,0));
        vecs.push_back(v(0,0,32'h0,  0,1,32'hFFFFFFFC,0, 1,32'hFFFFFFFC,1, 0,32'h0,32'h0, 0));
        vecs.push_back(v(1,0,32'h0,  0,0,32'h0,0, 0,32'h0,1, 0,32'h0,32'h0,   0));
        vecs.push_back(v(0,1,32'hFC, 0,0,32'h0,0, 1,32'h0,1, 1,32'hFFFFFFFC,32'hFC,0));
        vecs.push_back(v(1,0,32'h0,  0,1,32'h80,1,0,32'h0,0, 0,32'h0,32'h0,   1));
        vecs.push_back(v(1,1,32'h100,0,0,32'h0,0, 0,32'h0,0, 0,32'h0,32'h0,   1));
        vecs.push_back(v(1,0,32'h0,  1,1,32'h40,0,0,32'h0,0, 0,32'h0,32'h0,   1));

        do_reset();
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // reset while a request is outstanding: its late response must not be consumed
        do_reset();
        run_vec(v(1,0,32'h0,0,0,32'h0,0, 0,32'h4,1, 0,32'h0,32'h0,0), "mid");
        reset = 1'b0;
        #1;
        check("mid.async_req_valid", imem_req_valid, 1);
        check("mid.async_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_vec(v(0,1,32'hDEAD,0,0,32'h0,0, 1,32'h0,1, 0,32'h0,32'h0,0), "mid_stale");
        run_vec(v(1,0,32'h0,   0,0,32'h0,0, 0,32'h4,1, 0,32'h0,32'h0,0), "mid_acc");
        run_vec(v(0,1,32'h100, 0,0,32'h0,0, 1,32'h4,1, 1,32'h0,32'h100,0), "mid_load");

        // redirect in the same cycle a request is accepted
        do_reset();
        run_vec(v(1,0,32'h0,  0,1,32'h200,0, 0,32'h200,1, 0,32'h0,32'h0,0), "racc");
        run_vec(v(0,1,32'h100,0,0,32'h0,0,   1,32'h200,1, 0,32'h0,32'h0,0), "racc_drop");
        run_vec(v(1,0,32'h0,  0,0,32'h0,0,   0,32'h204,1, 0,32'h0,32'h0,0), "racc_acc");
        run_vec(v(0,1,32'h300,0,0,32'h0,0,   1,32'h204,1, 1,32'h200,32'h300,0), "racc_load");

        // response arriving together with a redirect in WAIT
        do_reset();
        run_vec(v(1,0,32'h0,  0,0,32'h0,0,  0,32'h4,1,  0,32'h0,32'h0,0), "rresp_acc");
        run_vec(v(0,1,32'h100,0,1,32'h80,0, 1,32'h80,1, 0,32'h0,32'h0,0), "rresp");
        run_vec(v(1,0,32'h0,  0,0,32'h0,0,  0,32'h84,1, 0,32'h0,32'h0,0), "rresp_acc2");
        run_vec(v(0,1,32'h180,0,0,32'h0,0,  1,32'h84,1, 1,32'h80,32'h180,0), "rresp_load");

        // randomized run: consumed instructions must form the in-order stream from the last redirect
        do_reset();
        pending = 0; cnt = 0; pend_data = '0; exp_pc = 32'h0; consumed = 0;
        prev_wait = 0; prev_hold = 0; prev_rdr = 0;
        prev_addr = '0; prev_ipc = '0; prev_iinst = '0;
        for (int c = 0; c < 3000; c++) begin
            rdy_r = ($urandom_range(0, 9) < 7);
            st_r  = ($urandom_range(0, 9) < 3);
            rdr_r = ($urandom_range(0, 19) == 0);
            rpc_r = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | $urandom_range(0, 15))
                                                : ($urandom & 32'h3FF);
            rv_r  = pending && (cnt == 0);

            if (imem_req_valid) check("rnd.align", {30'd0, imem_req_addr[1:0]}, 32'h0);
            if (pending) check("rnd.one_outstanding", imem_req_valid, 0);
            if (prev_wait) begin
                check("rnd.req_stable_valid", imem_req_valid, 1);
                check("rnd.req_stable_addr", imem_req_addr, prev_addr);
            end
            if (prev_hold) begin
                check("rnd.stall_valid", if_id_valid, 1);
                check("rnd.stall_pc", if_id_pc, prev_ipc);
                check("rnd.stall_inst", if_id_inst, prev_iinst);
            end
            if (prev_rdr) check("rnd.flush", if_id_valid, 0);
            if (if_id_valid && !st_r && !rdr_r) begin
                check("rnd.stream_pc", if_id_pc, exp_pc);
                check("rnd.stream_inst", if_id_inst, exp_pc + 32'h100);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (rdr_r) exp_pc = {rpc_r[31:2], 2'b00};

            accept_now = imem_req_valid && rdy_r;
            acc_addr   = imem_req_addr;
            prev_wait  = imem_req_valid && !rdy_r && !rdr_r;
            prev_hold  = if_id_valid && st_r && !rdr_r;
            prev_rdr   = rdr_r;
            prev_addr  = imem_req_addr;
            prev_ipc   = if_id_pc;
            prev_iinst = if_id_inst;

            drive(rdy_r, rv_r, pend_data, st_r, rdr_r, rpc_r, 1'b0);
            @(posedge clk);
            if (rv_r) pending = 0;
            else if (pending && cnt != 0) cnt--;
            if (accept_now) begin
                pending   = 1;
                cnt       = $urandom_range(0, 3);
                pend_data = acc_addr + 32'h100;
            end
            @(negedge clk);
        end
        check("rnd.progress", {31'd0, consumed > 100}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
